rf_arbiter: RTL and testbench
=============================

RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameter ZERO_REG_PROTECT, default 1: when 1, writes to register 0 are accepted and acknowledged, but never reach memory.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester access request; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester grant; a handshake occurs when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-006 req_we  input  2  1 = write access, 0 = read access.
REQ-007 req_waddr  input  10  write address; requester i uses bits [5i+4:5i].
REQ-008 req_wdata  input  64  write data; requester i uses bits [32i+31:32i].
REQ-009 req_raddr1, req_raddr2  input  10 each  read addresses, packed as req_waddr.
REQ-010 rsp_valid  output  2  one-cycle read-response strobe for requester i.
REQ-011 rsp_data1, rsp_data2  output  32 each  read data, shared by both requesters and qualified by rsp_valid.
REQ-012 wr_ack  output  2  one-cycle write-completion strobe for requester i.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 mem_wr_en, mem_wr_addr(5), mem_wr_data(32)  output  drive the register-file write port.
REQ-015 mem_rd_en, mem_rd_addr1(5), mem_rd_addr2(5)  output  drive the register-file read ports.
REQ-016 mem_rd_data1, mem_rd_data2  input  32 each  register-file read data, valid one cycle after mem_rd_en.

Function
REQ-017 FSM states: IDLE, RD, RSP, WR. The FSM SHALL hold exactly one access in flight at a time.
REQ-018 IDLE behaviour:
- req_ready is a combinational one-hot grant, driven only in IDLE.
- It goes to the single valid requester; if both are valid, it goes to the requester selected by the round-robin pointer.
REQ-019 On handshake the block SHALL:
- latch the granted index, we, addresses and data;
- move the pointer to the other requester;
- go to WR if we=1, else RD.
REQ-020 RD (one cycle): mem_rd_en=1, with mem_rd_addr1/2 = latched addresses; next state is RSP.
REQ-021 RSP (one cycle): rsp_valid[g]=1, rsp_data1/2 = registered capture of mem_rd_data1/2; next state is IDLE.
- Read latency is 2 cycles from the handshake edge to the rsp_valid cycle.
REQ-022 WR (one cycle): mem_wr_en=1, with latched address and data; wr_ack[g]=1; next state is IDLE.
REQ-023 Register 0 protection: if ZERO_REG_PROTECT=1 and the latched waddr=0, mem_wr_en SHALL stay 0 in WR, and wr_ack still pulses.
REQ-024 Parking of the write address:
- The register file clears mem[mem_wr_addr] on every cycle in which mem_wr_en=0.
- The block SHALL therefore drive mem_wr_addr=0 and mem_wr_data=0 in every cycle in which mem_wr_en=0.
REQ-025 Idle read port: mem_rd_en=0 and mem_rd_addr1/2=0 outside RD.
REQ-026 rsp_data1/2 SHALL hold their last value when rsp_valid=0.
REQ-027 Requests are never dropped: req_valid held while not granted waits, and ordering inside each requester is preserved.
REQ-028 Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1,...
REQ-029 A requester may deassert req_valid before it is granted; it is then not serviced.
REQ-030 A req_valid first asserted while the FSM is outside IDLE is arbitrated at the next IDLE cycle.

Reset
REQ-031 Reset assertion SHALL act immediately, independent of clk:
- FSM to IDLE, pointer to requester 0;
- all outputs 0, including rsp_data1/2;
- any in-flight access is discarded with no rsp_valid or wr_ack;
- a write aborted mid-WR may or may not have committed.
REQ-032 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-033 Read: requester 0 reads addresses 3 and 7 (mem holds 0x11, 0x22).
-> Handshake at cycle T, mem_rd_en=1 at T+1, rsp_valid=2'b01 with rsp_data1=0x11 and rsp_data2=0x22 at T+2.
REQ-034 Write then read: requester 1 writes 0xDEADBEEF to address 5, then reads 5/5.
-> wr_ack=2'b10 one cycle after the handshake, then rsp_data1=rsp_data2=0xDEADBEEF.
REQ-035 Contention: both requesters valid for 8 accesses each.
-> Grants alternate starting with requester 0, there are 16 responses, and busy never drops between back-to-back grants for longer than one IDLE cycle.
REQ-036 Register 0 protection: write 0x5 to address 0.
-> wr_ack pulses, mem_wr_en stays 0, and a subsequent read of address 0 returns 0.
REQ-037 Write-address parking: while idle for 100 cycles, mem_wr_addr=0 throughout.
-> Data previously written to address 9 is still readable.
REQ-038 Reset during RD: assert rst in RD.
-> All outputs 0 at once, no rsp_valid, and the next request after deassertion completes normally.

Source files
------------

// File: rtl/rf_arbiter.sv
// Two-requester arbiter in front of a register file with one write port and two
// read ports. One access is in flight at a time, and round-robin breaks ties.
module rf_arbiter #(
    parameter bit ZERO_REG_PROTECT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [9:0]  req_waddr,
    input  logic [63:0] req_wdata,
    input  logic [9:0]  req_raddr1,
    input  logic [9:0]  req_raddr2,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data1,
    output logic [31:0] rsp_data2,
    output logic [1:0]  wr_ack,
    output logic        busy,
    output logic        mem_wr_en,
    output logic [4:0]  mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_rd_en,
    output logic [4:0]  mem_rd_addr1,
    output logic [4:0]  mem_rd_addr2,
    input  logic [31:0] mem_rd_data1,
    input  logic [31:0] mem_rd_data2
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RSP  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_d;
    logic          ptr;
    logic          gnt_idx;
    logic [AW-1:0] lat_waddr;
    logic [DW-1:0] lat_wdata;
    logic [AW-1:0] lat_raddr1;
    logic [AW-1:0] lat_raddr2;
    logic [DW-1:0] rsp_hold1;
    logic [DW-1:0] rsp_hold2;

    logic          sel_c;
    logic [1:0]    grant_c;
    logic          hs_c;
    logic          wr_blocked_c;

    // Arbitration: a lone requester wins, a tie goes to the round-robin pointer
    always_comb begin
        sel_c   = (req_valid == 2'b11) ? ptr : req_valid[1];
        grant_c = 2'b00;
        if ((state == IDLE) && rst && (req_valid != 2'b00)) begin
            grant_c = sel_c ? 2'b10 : 2'b01;
        end
        hs_c         = |(req_valid & grant_c);
        wr_blocked_c = ZERO_REG_PROTECT && (lat_waddr == '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;
        wr_ack       = 2'b00;
        busy         = (state != IDLE);
        mem_rd_en    = 1'b0;
        mem_rd_addr1 = '0;
        mem_rd_addr2 = '0;
        mem_wr_en    = 1'b0;
        mem_wr_addr  = '0;
        mem_wr_data  = '0;
        rsp_data1    = rsp_hold1;
        rsp_data2    = rsp_hold2;
        case (state)
            IDLE: begin
                req_ready = grant_c;
                if (hs_c) begin
                    state_d = (sel_c ? req_we[1] : req_we[0]) ? WR : RD;
                end
            end
            RD: begin
                mem_rd_en    = 1'b1;
                mem_rd_addr1 = lat_raddr1;
                mem_rd_addr2 = lat_raddr2;
                state_d      = RSP;
            end
            RSP: begin
                // Read data arrives registered from the memory in this cycle
                rsp_valid = gnt_idx ? 2'b10 : 2'b01;
                rsp_data1 = mem_rd_data1;
                rsp_data2 = mem_rd_data2;
                state_d   = IDLE;
            end
            WR: begin
                wr_ack = gnt_idx ? 2'b10 : 2'b01;
                // Address and data stay parked at zero unless a write really commits
                if (!wr_blocked_c) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = lat_waddr;
                    mem_wr_data = lat_wdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the granted request and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= 1'b0;
            gnt_idx    <= 1'b0;
            lat_waddr  <= '0;
            lat_wdata  <= '0;
            lat_raddr1 <= '0;
            lat_raddr2 <= '0;
        end else if (hs_c) begin
            ptr        <= ~sel_c;
            gnt_idx    <= sel_c;
            lat_waddr  <= sel_c ? req_waddr[9:5]    : req_waddr[4:0];
            lat_wdata  <= sel_c ? req_wdata[63:32]  : req_wdata[31:0];
            lat_raddr1 <= sel_c ? req_raddr1[9:5]   : req_raddr1[4:0];
            lat_raddr2 <= sel_c ? req_raddr2[9:5]   : req_raddr2[4:0];
        end
    end

    // Keep the last read response visible between strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_hold1 <= '0;
            rsp_hold2 <= '0;
        end else if (state == RSP) begin
            rsp_hold1 <= mem_rd_data1;
            rsp_hold2 <= mem_rd_data2;
        end
    end

endmodule

// File: tb/tb_rf_arbiter.sv
// Bench for rf_arbiter: a register-file model, two requester agents, and a
// transaction-level reference that predicts grants, latencies and data.
module tb_rf_arbiter;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [9:0]  req_waddr;
    logic [63:0] req_wdata;
    logic [9:0]  req_raddr1;
    logic [9:0]  req_raddr2;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data1;
    logic [31:0] rsp_data2;
    logic [1:0]  wr_ack;
    logic        busy;
    logic        mem_wr_en;
    logic [4:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_rd_en;
    logic [4:0]  mem_rd_addr1;
    logic [4:0]  mem_rd_addr2;
    logic [31:0] mem_rd_data1;
    logic [31:0] mem_rd_data2;

    logic        mem_init;
    logic [31:0] tb_mem [32];

    int          n_checks = 0;
    int          n_fail   = 0;

    op_t         q0[$];
    op_t         q1[$];
    logic [31:0] shadow [32];
    int          m_phase;
    int          m_g;
    int          m_last;
    op_t         m_op;
    logic [31:0] m_exp1, m_exp2, m_hold1, m_hold2;
    int          n_done;
    bit          hold_mode;
    bit          log_en;
    int          glog[$];

    rf_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_waddr    (req_waddr),
        .req_wdata    (req_wdata),
        .req_raddr1   (req_raddr1),
        .req_raddr2   (req_raddr2),
        .rsp_valid    (rsp_valid),
        .rsp_data1    (rsp_data1),
        .rsp_data2    (rsp_data2),
        .wr_ack       (wr_ack),
        .busy         (busy),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr1 (mem_rd_addr1),
        .mem_rd_addr2 (mem_rd_addr2),
        .mem_rd_data1 (mem_rd_data1),
        .mem_rd_data2 (mem_rd_data2)
    );

    always #5 clk = ~clk;

    // Register file: registered reads, and clears mem[mem_wr_addr] whenever not writing
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= '0;
        end else begin
            if (mem_rd_en) begin
                mem_rd_data1 <= tb_mem[mem_rd_addr1];
                mem_rd_data2 <= tb_mem[mem_rd_addr2];
            end
            if (mem_wr_en) tb_mem[mem_wr_addr] <= mem_wr_data;
            else           tb_mem[mem_wr_addr] <= '0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk_wr(input logic [4:0] a, input logic [31:0] d);
        op_t o;
        o = '0;
        o.we = 1'b1;
        o.waddr = a;
        o.wdata = d;
        return o;
    endfunction

    function automatic op_t mk_rd(input logic [4:0] a1, input logic [4:0] a2);
        op_t o;
        o = '0;
        o.ra1 = a1;
        o.ra2 = a2;
        return o;
    endfunction

    function automatic op_t mk_rand();
        op_t o;
        o.we    = 1'($urandom_range(0, 1));
        o.waddr = 5'($urandom_range(0, 11));
        o.wdata = $urandom;
        o.ra1   = 5'($urandom_range(0, 11));
        o.ra2   = 5'($urandom_range(0, 11));
        return o;
    endfunction

    task automatic drive_inputs();
        op_t  h0, h1;
        logic v0, v1;
        h0 = '0;
        h1 = '0;
        if (q0.size() > 0) h0 = q0[0];
        if (q1.size() > 0) h1 = q1[0];
        v0 = (q0.size() > 0) && (hold_mode || ($urandom_range(0, 3) != 0));
        v1 = (q1.size() > 0) && (hold_mode || ($urandom_range(0, 3) != 0));
        req_valid  = {v1, v0};
        req_we     = {h1.we, h0.we};
        req_waddr  = {h1.waddr, h0.waddr};
        req_wdata  = {h1.wdata, h0.wdata};
        req_raddr1 = {h1.ra1, h0.ra1};
        req_raddr2 = {h1.ra2, h0.ra2};
    endtask

    task automatic check_outputs();
        logic [1:0] gbit;
        logic       exp_wen;
        gbit    = (m_g == 1) ? 2'b10 : 2'b01;
        exp_wen = (m_phase == 3) && (m_op.waddr != 5'd0);
        check("busy",         64'(busy),         64'(m_phase != 0));
        check("mem_rd_en",    64'(mem_rd_en),    64'(m_phase == 1));
        check("mem_rd_addr1", 64'(mem_rd_addr1), 64'((m_phase == 1) ? m_op.ra1 : 5'd0));
        check("mem_rd_addr2", 64'(mem_rd_addr2), 64'((m_phase == 1) ? m_op.ra2 : 5'd0));
        check("rsp_valid",    64'(rsp_valid),    64'((m_phase == 2) ? gbit : 2'b00));
        check("rsp_data1",    64'(rsp_data1),    64'((m_phase == 2) ? m_exp1 : m_hold1));
        check("rsp_data2",    64'(rsp_data2),    64'((m_phase == 2) ? m_exp2 : m_hold2));
        check("wr_ack",       64'(wr_ack),       64'((m_phase == 3) ? gbit : 2'b00));
        check("mem_wr_en",    64'(mem_wr_en),    64'(exp_wen));
        check("mem_wr_addr",  64'(mem_wr_addr),  64'(exp_wen ? m_op.waddr : 5'd0));
        check("mem_wr_data",  64'(mem_wr_data),  64'(exp_wen ? m_op.wdata : 32'd0));
    endtask

    // One clock of stimulus plus reference-model bookkeeping
    task automatic step();
        logic [1:0] exp_ready;
        op_t        o;
        @(negedge clk);
        drive_inputs();
        #1;
        check_outputs();
        exp_ready = 2'b00;
        if (m_phase == 0) begin
            if (req_valid == 2'b11) exp_ready = (m_last == 0) ? 2'b10 : 2'b01;
            else                    exp_ready = req_valid;
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        case (m_phase)
            1: m_phase = 2;
            2: begin
                m_hold1 = m_exp1;
                m_hold2 = m_exp2;
                m_phase = 0;
                n_done++;
            end
            3: begin
                if (m_op.waddr != 5'd0) shadow[m_op.waddr] = m_op.wdata;
                m_phase = 0;
                n_done++;
            end
            default: begin
                if (exp_ready != 2'b00) begin
                    m_g = exp_ready[1] ? 1 : 0;
                    if (m_g == 1) o = q1.pop_front();
                    else          o = q0.pop_front();
                    m_op   = o;
                    m_last = m_g;
                    if (log_en) glog.push_back(m_g);
                    if (o.we) begin
                        m_phase = 3;
                    end else begin
                        m_phase = 1;
                        m_exp1  = shadow[o.ra1];
                        m_exp2  = shadow[o.ra2];
                    end
                end
            end
        endcase
    endtask

    task automatic run_until_done(input int budget);
        int cyc;
        cyc = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_phase != 0) && cyc < budget) begin
            step();
            cyc++;
        end
        if (q0.size() != 0 || q1.size() != 0 || m_phase != 0)
            check("timeout", 64'(cyc), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  64'(req_ready),                 64'(0));
        check({tag, "_rsp"},    64'(rsp_valid),                 64'(0));
        check({tag, "_ack"},    64'(wr_ack),                    64'(0));
        check({tag, "_busy"},   64'(busy),                      64'(0));
        check({tag, "_rd"},     64'({mem_rd_en, mem_rd_addr1, mem_rd_addr2}), 64'(0));
        check({tag, "_wr"},     64'({mem_wr_en, mem_wr_addr}),  64'(0));
        check({tag, "_wdata"},  64'(mem_wr_data),               64'(0));
        check({tag, "_rdata"},  {rsp_data2, rsp_data1},         64'(0));
    endtask

    initial begin
        int cnt;
        int base;
        rst        = 1'b0;
        mem_init   = 1'b1;
        req_valid  = '0;
        req_we     = '0;
        req_waddr  = '0;
        req_wdata  = '0;
        req_raddr1 = '0;
        req_raddr2 = '0;
        hold_mode  = 1'b0;
        log_en     = 1'b0;
        m_phase    = 0;
        m_g        = 0;
        m_last     = 1;
        m_op       = '0;
        m_exp1     = '0;
        m_exp2     = '0;
        m_hold1    = '0;
        m_hold2    = '0;
        n_done     = 0;
        for (int i = 0; i < 32; i++) shadow[i] = '0;

        // Reset state, with requests pending that must not be granted yet
        repeat (3) @(negedge clk);
        req_valid = 2'b11;
        #1;
        check_all_zero("reset");
        req_valid = 2'b00;
        mem_init  = 1'b0;
        rst       = 1'b1;

        // Seed two registers, then read them back in one access
        q0.push_back(mk_wr(5'd3, 32'h11));
        q0.push_back(mk_wr(5'd7, 32'h22));
        run_until_done(100);
        q0.push_back(mk_rd(5'd3, 5'd7));
        run_until_done(100);

        // Write-then-read from requester 1
        q1.push_back(mk_wr(5'd5, 32'hDEADBEEF));
        q1.push_back(mk_rd(5'd5, 5'd5));
        run_until_done(100);

        // Register 0 protection
        q0.push_back(mk_wr(5'd0, 32'h5));
        q0.push_back(mk_rd(5'd0, 5'd0));
        run_until_done(100);

        // Long idle with the write port parked, then data at 9 must survive
        q0.push_back(mk_wr(5'd9, 32'hCAFE0009));
        run_until_done(100);
        repeat (100) step();
        q1.push_back(mk_rd(5'd9, 5'd3));
        run_until_done(100);

        // Reset while a read sits in RD
        hold_mode = 1'b1;
        q0.push_back(mk_rd(5'd3, 5'd7));
        cnt = 0;
        while (m_phase != 1 && cnt < 50) begin
            step();
            cnt++;
        end
        @(posedge clk);
        #2;
        check("rd_before_reset", 64'(mem_rd_en), 64'(1));
        rst = 1'b0;
        #1;
        check_all_zero("mid_rd_reset");
        req_valid = 2'b00;
        repeat (2) begin
            @(negedge clk);
            check("reset_hold_rsp", 64'(rsp_valid), 64'(0));
        end
        rst     = 1'b1;
        m_phase = 0;
        m_last  = 1;
        m_hold1 = '0;
        m_hold2 = '0;
        q1.push_back(mk_rd(5'd3, 5'd7));
        run_until_done(100);

        // Contention: both requesters continuously valid
        log_en = 1'b1;
        glog.delete();
        base = n_done;
        for (int i = 0; i < 8; i++) begin
            q0.push_back(mk_rand());
            q1.push_back(mk_rand());
        end
        run_until_done(400);
        check("contention_done", 64'(n_done - base), 64'(16));
        check("contention_grants", 64'(glog.size()), 64'(16));
        for (int k = 0; k < glog.size(); k++)
            check("contention_order", 64'(glog[k]), 64'(k % 2));
        log_en = 1'b0;

        // Randomized traffic with requests that come and go
        hold_mode = 1'b0;
        for (int i = 0; i < 150; i++) begin
            q0.push_back(mk_rand());
            q1.push_back(mk_rand());
        end
        run_until_done(5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
